// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (FETCH / HOLD / REDIRECT)
//   if_id_t       : IF/ID pipeline register contents {insn, pc4, valid}
//   NOP_INSN      : instruction value used for bubbles and flushes
//   PC_STEP       : PC increment per sequential fetch
//   word_align()  : clears the two low address bits of a branch target
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StRedirect
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry instruction buffer that catches a response arriving
// while the pipeline is stalled.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : capture data_i, mark entry valid
//   clear_i   : drop the entry (load_i wins if both are set)
//   data_i    : instruction to capture
//   data_o    : buffered instruction
//   valid_o   : entry holds an instruction
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o
);

    logic [31:0] data_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the PC, the instruction-memory
// request, and the IF/ID register. Freezes on Write=0, buffers a response that
// lands during a stall, and flushes on branch_taken.
//   clk, rst                     : clock, asynchronous active-high reset
//   Write                        : 1 = ID consumes IF/ID this cycle, 0 = stall
//   branch_taken, branch_target  : redirect request and new PC
//   imem_req, imem_addr          : fetch request (Moore outputs)
//   imem_ready, imem_rdata       : fetch response
//   if_id_insn/pc4/valid         : IF/ID register
//   stall_cycles, flush_count    : perf counters, present only when the
//                                  FETCH_PERF_EN macro is defined
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_insn,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    if_id_t       ifid_q, ifid_d;
    // Keeps imem_req low until the first edge after reset release.
    logic         started_q;

    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_data;

    logic         rsp;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;

    assign imem_req  = started_q && (state_q != StHold);
    assign imem_addr = pc_q;
    // A response only counts against a request we are actually making.
    assign rsp       = imem_ready && imem_req;
    assign pc_plus4  = pc_q + PC_STEP;
    assign target    = word_align(branch_target);

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (imem_rdata),
        .data_o  (skid_data),
        .valid_o (skid_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        ifid_d     = ifid_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        // Flush/bubble leave pc4 as it was.
        if (branch_taken) begin
            ifid_d.insn  = NOP_INSN;
            ifid_d.valid = 1'b0;
        end

        unique case (state_q)
            StFetch: begin
                if (branch_taken) begin
                    if (rsp) begin
                        pc_d = target;
                    end else begin
                        redir_d = target;
                        state_d = StRedirect;
                    end
                end else if (rsp) begin
                    if (Write) begin
                        ifid_d = '{insn: imem_rdata, pc4: pc_plus4, valid: 1'b1};
                        pc_d   = pc_plus4;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end
                end else if (Write) begin
                    ifid_d.insn  = NOP_INSN;
                    ifid_d.valid = 1'b0;
                end
            end
            StHold: begin
                if (branch_taken) begin
                    skid_clear = 1'b1;
                    pc_d       = target;
                    state_d    = StFetch;
                end else if (Write && skid_valid) begin
                    ifid_d     = '{insn: skid_data, pc4: pc_plus4, valid: 1'b1};
                    pc_d       = pc_plus4;
                    skid_clear = 1'b1;
                    state_d    = StFetch;
                end
            end
            StRedirect: begin
                if (branch_taken) begin
                    redir_d = target;
                end
                // Stale response is discarded; the newest target wins.
                if (rsp) begin
                    pc_d    = branch_taken ? target : redir_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= PC_RESET;
            redir_q   <= 32'h0;
            ifid_q    <= '{insn: NOP_INSN, pc4: 32'h0, valid: 1'b0};
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            ifid_q    <= ifid_d;
            started_q <= 1'b1;
        end
    end

    assign if_id_insn  = ifid_q.insn;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'h0;
            flush_q <= 32'h0;
        end else begin
            stall_q <= stall_q + {31'h0, ~Write};
            flush_q <= flush_q + {31'h0, branch_taken};
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] PCR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_id_insn;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    if_fetch_stage #(.PC_RESET(PCR)) dut (
        .clk           (clk),
        .rst           (rst),
        .Write         (Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_insn    (if_id_insn),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Model: what the stage must present, from the fetch rules.
    logic [31:0] m_pc, m_insn, m_pc4;
    bit          m_valid, m_started;
    logic [31:0] m_buf[$];     // instruction caught during a stall
    logic [31:0] m_redir[$];   // target waiting for a stale response
    logic [31:0] m_stall, m_flush;
    int          waits = 0;
    int          wcnt  = 0;
    bit          cmp_en = 1'b0;

    function automatic bit m_req();
        return m_started && (m_buf.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc = PCR; m_insn = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_started = 1'b0;
        m_buf.delete(); m_redir.delete();
        m_stall = 32'h0; m_flush = 32'h0; wcnt = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
            if (m_req()) chk("imem_addr", imem_addr, m_pc);
            chk("if_id_insn", if_id_insn, m_insn);
            chk("if_id_pc4", if_id_pc4, m_pc4);
            chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_PERF_EN
            chk("stall_cycles", stall_cycles, m_stall);
            chk("flush_count", flush_count, m_flush);
`endif
        end
    end

    // Called at posedge+2: drives one cycle of inputs, advances the model at the edge.
    task automatic step(input bit w, input bit br, input logic [31:0] tgt);
        bit          rdy;
        logic [31:0] rd, t;
        logic [31:0] n_pc, n_insn, n_pc4;
        bit          n_valid;
        logic [31:0] n_buf[$];
        logic [31:0] n_redir[$];
        rdy = 1'b0;
        rd  = 32'hBAD0_BAD0;
        if (m_req()) begin
            if (wcnt >= waits) begin
                rdy = 1'b1; rd = insn_of(m_pc); wcnt = 0;
            end else begin
                wcnt++;
            end
        end
        Write = w; branch_taken = br; branch_target = tgt;
        imem_ready = rdy; imem_rdata = rd;

        t = {tgt[31:2], 2'b00};
        n_pc = m_pc; n_insn = m_insn; n_pc4 = m_pc4; n_valid = m_valid;
        n_buf = m_buf; n_redir = m_redir;
        if (br) begin n_insn = 32'h0; n_valid = 1'b0; end
        if (m_redir.size() != 0) begin
            if (br) n_redir[0] = t;
            if (rdy) begin n_pc = n_redir[0]; n_redir.delete(); end
        end else if (m_buf.size() != 0) begin
            if (br) begin
                n_buf.delete(); n_pc = t;
            end else if (w) begin
                n_insn = m_buf[0]; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
                n_pc = m_pc + 32'd4; n_buf.delete();
            end
        end else begin
            if (br && rdy)       n_pc = t;
            else if (br)         n_redir.push_back(t);
            else if (rdy && w) begin
                n_insn = rd; n_pc4 = m_pc + 32'd4; n_valid = 1'b1; n_pc = m_pc + 32'd4;
            end
            else if (rdy)        n_buf.push_back(rd);
            else if (w) begin n_insn = 32'h0; n_valid = 1'b0; end
        end

        @(posedge clk);
        m_pc = n_pc; m_insn = n_insn; m_pc4 = n_pc4; m_valid = n_valid;
        m_buf = n_buf; m_redir = n_redir; m_started = 1'b1;
        m_stall = m_stall + {31'h0, ~w};
        m_flush = m_flush + {31'h0, br};
        #2;
    endtask

    // Called at posedge+2: asserts rst mid-cycle, checks reset values at once.
    task automatic do_reset();
        Write = 1'b1; branch_taken = 1'b0; imem_ready = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0000_0100);
        chk("rst_insn", if_id_insn, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_flush", flush_count, 32'h0);
`endif
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #2;
        do_reset();
        cmp_en = 1'b1;

        // Sequential fetch, zero-wait memory.
        step(1, 0, 0);
        chk("start_addr", imem_addr, 32'h100);
        chk("start_req", {31'h0, imem_req}, 32'h1);
        step(1, 0, 0);
        chk("seq_pc4_0", if_id_pc4, 32'h104);
        chk("seq_insn_0", if_id_insn, 32'h1357_9ADF);
        chk("seq_addr_1", imem_addr, 32'h104);
        step(1, 0, 0);
        chk("seq_pc4_1", if_id_pc4, 32'h108);
        chk("seq_addr_2", imem_addr, 32'h108);

        // Stall with response at 0x200.
        step(1, 1, 32'h200);
        step(0, 0, 0);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("hold_frozen_valid", {31'h0, if_id_valid}, 32'h0);
        step(1, 0, 0);
        chk("release_insn", if_id_insn, 32'h1357_99DF);
        chk("release_pc4", if_id_pc4, 32'h204);
        chk("release_addr", imem_addr, 32'h204);

        // Branch coinciding with a response at 0x300.
        step(1, 1, 32'h300);
        step(1, 1, 32'h400);
        chk("br_rdy_valid", {31'h0, if_id_valid}, 32'h0);
        chk("br_rdy_addr", imem_addr, 32'h400);
        step(1, 0, 0);

        // Branch during a 2-wait fetch at 0x300; unaligned target.
        step(1, 1, 32'h300);
        waits = 2; wcnt = 0;
        step(1, 1, 32'h502);
        chk("redir_addr_0", imem_addr, 32'h300);
        step(1, 0, 0);
        chk("redir_addr_1", imem_addr, 32'h300);
        step(1, 0, 0);
        chk("redir_target", imem_addr, 32'h500);
        chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
        repeat (3) step(1, 0, 0);
        chk("after_redir_insn", if_id_insn, 32'h1357_9EDF);

        // Branch with Write=0 while holding a buffered instruction.
        waits = 0; wcnt = 0;
        step(0, 0, 0);
        step(0, 1, 32'h600);
        chk("hold_br_req", {31'h0, imem_req}, 32'h1);
        chk("hold_br_addr", imem_addr, 32'h600);
        step(1, 0, 0);
        chk("hold_br_insn", if_id_insn, 32'h1357_9DDF);

        // PC+4 wraps.
        step(1, 1, 32'hFFFF_FFFC);
        step(1, 0, 0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Second branch overwrites a pending redirect.
        waits = 2; wcnt = 0;
        step(1, 1, 32'h700);
        step(1, 1, 32'h800);
        step(1, 0, 0);
        chk("overwrite_addr", imem_addr, 32'h800);
        step(1, 0, 0);

`ifdef FETCH_PERF_EN
        waits = 0;
        do_reset();
        step(1, 0, 0);
        repeat (5) step(0, 0, 0);
        repeat (2) step(1, 1, 32'h900);
        chk("perf_stall", stall_cycles, 32'd5);
        chk("perf_flush", flush_count, 32'd2);
`endif

        // Reset in the middle of a wait-stated fetch.
        waits = 2; wcnt = 0;
        step(1, 0, 0);
        do_reset();
        waits = 0;
        repeat (3) step(1, 0, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
